// File: rtl/operand_stream_buffer_pkg.sv
// Shared types and helpers for the operand stream buffer and the matmul top.
package operand_stream_buffer_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_BUS_WIDTH  = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Index width that never collapses to zero bits for tiny matrices.
   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int elem_lsb(input int e, input int w);
      return e * w;
   endfunction

endpackage

// File: rtl/operand_stream_buffer_if.sv
// Bus-write, control and PE-stream signals of the operand stream buffer.
interface operand_stream_buffer_if
   import operand_stream_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BUS_WIDTH  = DEF_BUS_WIDTH
);
   localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
   localparam int AW      = clog2_safe(MAX_DIM);

   logic                 wr_en_i;
   logic                 wr_bank_i;
   logic [AW-1:0]        wr_addr_i;
   logic [BUS_WIDTH-1:0] wr_data_i;
   logic [MAX_DIM-1:0]   wr_strb_i;
   logic                 clear_i;
   logic                 start_i;
   logic [AW-1:0]        dim_i;
   logic                 transpose_b_i;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [BUS_WIDTH-1:0] out_a_o;
   logic [BUS_WIDTH-1:0] out_b_o;
   logic [AW-1:0]        out_idx_o;
   logic                 out_last_o;
   logic                 busy_o;
   logic                 done_o;
   logic                 err_o;

   modport slave (
      input  wr_en_i, wr_bank_i, wr_addr_i, wr_data_i, wr_strb_i, clear_i,
             start_i, dim_i, transpose_b_i, out_ready_i,
      output out_valid_o, out_a_o, out_b_o, out_idx_o, out_last_o,
             busy_o, done_o, err_o
   );

   modport master (
      output wr_en_i, wr_bank_i, wr_addr_i, wr_data_i, wr_strb_i, clear_i,
             start_i, dim_i, transpose_b_i, out_ready_i,
      input  out_valid_o, out_a_o, out_b_o, out_idx_o, out_last_o,
             busy_o, done_o, err_o
   );

endinterface

// File: rtl/operand_stream_buffer_bank.sv
// One MAX_DIM x MAX_DIM element bank: strobed row write, clear, row and column reads.
module operand_stream_buffer_bank
   import operand_stream_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
   localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
   localparam int AW        = clog2_safe(MAX_DIM)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 i_clear,
   input  logic                 i_we,
   input  logic [AW-1:0]        i_waddr,
   input  logic [BUS_WIDTH-1:0] i_wdata,
   input  logic [MAX_DIM-1:0]   i_wstrb,
   input  logic [AW-1:0]        i_row_addr,
   output logic [BUS_WIDTH-1:0] o_row,
   input  logic [AW-1:0]        i_col_idx,
   output logic [BUS_WIDTH-1:0] o_col
);

   logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] r_mem;
   logic [MAX_DIM-1:0][DATA_WIDTH-1:0]              w_wdata;
   logic [MAX_DIM-1:0][DATA_WIDTH-1:0]              w_col;

   assign w_wdata = i_wdata;

   // Clear wins over a same-cycle write; unstrobed elements keep their value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mem <= '0;
      end else if (i_clear) begin
         r_mem <= '0;
      end else if (i_we) begin
         for (int e = 0; e < MAX_DIM; e++) begin
            if (i_wstrb[e]) r_mem[i_waddr][e] <= w_wdata[e];
         end
      end
   end

   assign o_row = r_mem[i_row_addr];

   for (genvar r = 0; r < MAX_DIM; r++) begin : g_col
      assign w_col[r] = r_mem[r][i_col_idx];
   end

   assign o_col = w_col;

endmodule

// File: rtl/operand_stream_buffer.sv
// Dual-bank operand store feeding the PE array: A rows paired with B rows or columns.
module operand_stream_buffer
   import operand_stream_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BUS_WIDTH  = DEF_BUS_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   operand_stream_buffer_if.slave  bus
);

   localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
   localparam int AW      = clog2_safe(MAX_DIM);

   state_t               r_state;
   logic [AW-1:0]        r_idx;
   logic [AW-1:0]        r_dim;
   logic                 r_transpose;
   logic                 r_valid;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_err;

   logic                 w_idle;
   logic                 w_clear;
   logic                 w_we_a;
   logic                 w_we_b;
   logic                 w_xfer;
   logic                 w_last;
   logic [BUS_WIDTH-1:0] w_a_row;
   logic [BUS_WIDTH-1:0] w_b_row;
   logic [BUS_WIDTH-1:0] w_b_col;
   logic [BUS_WIDTH-1:0] w_unused_a_col;
   logic [BUS_WIDTH-1:0] w_b_sel;
   logic [BUS_WIDTH-1:0] w_emask;

   assign w_idle  = (r_state == ST_IDLE);
   assign w_clear = bus.clear_i & w_idle;
   assign w_we_a  = bus.wr_en_i & ~bus.wr_bank_i & w_idle;
   assign w_we_b  = bus.wr_en_i &  bus.wr_bank_i & w_idle;
   assign w_xfer  = r_valid & bus.out_ready_i;
   assign w_last  = (r_idx == r_dim);

   operand_stream_buffer_bank #(.DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH)) u_bank_a (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_clear    (w_clear),
      .i_we       (w_we_a),
      .i_waddr    (bus.wr_addr_i),
      .i_wdata    (bus.wr_data_i),
      .i_wstrb    (bus.wr_strb_i),
      .i_row_addr (r_idx),
      .o_row      (w_a_row),
      .i_col_idx  (r_idx),
      .o_col      (w_unused_a_col)
   );

   operand_stream_buffer_bank #(.DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH)) u_bank_b (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_clear    (w_clear),
      .i_we       (w_we_b),
      .i_waddr    (bus.wr_addr_i),
      .i_wdata    (bus.wr_data_i),
      .i_wstrb    (bus.wr_strb_i),
      .i_row_addr (r_idx),
      .o_row      (w_b_row),
      .i_col_idx  (r_idx),
      .o_col      (w_b_col)
   );

   // Elements beyond the active dimension are zeroed so the PEs see a clean edge.
   for (genvar e = 0; e < MAX_DIM; e++) begin : g_mask
      assign w_emask[elem_lsb(e, DATA_WIDTH) +: DATA_WIDTH] =
         (AW'(e) <= r_dim) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
   end

   assign w_b_sel = r_transpose ? w_b_col : w_b_row;

   // Storage is frozen while busy, so stalled beats stay stable without extra registers.
   assign bus.out_valid_o = r_valid;
   assign bus.out_a_o     = r_valid ? (w_a_row & w_emask) : '0;
   assign bus.out_b_o     = r_valid ? (w_b_sel & w_emask) : '0;
   assign bus.out_idx_o   = r_valid ? r_idx : '0;
   assign bus.out_last_o  = r_valid & w_last;
   assign bus.busy_o      = r_busy;
   assign bus.done_o      = r_done;
   assign bus.err_o       = r_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_dim       <= '0;
         r_transpose <= 1'b0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_err  <= (bus.wr_en_i | bus.clear_i) & ~w_idle;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start_i) begin
                  r_state     <= ST_STREAM;
                  r_dim       <= bus.dim_i;
                  r_transpose <= bus.transpose_b_i;
                  r_idx       <= '0;
                  r_valid     <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            ST_STREAM: begin
               if (w_xfer) begin
                  if (w_last) begin
                     r_state <= ST_DONE;
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx <= r_idx + AW'(1);
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_idx   <= '0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_idx   <= '0;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
